// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and handshaked instruction fetch for the single-cycle core.
// Optional: define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   imem_req_o, imem_addr_o  fetch request / address (addr = pc)
//   imem_ack_i, imem_rdata_i memory response, data valid with ack
//   stall_i                  downstream busy, extends the execute window
//   pc_sel_i, alu_data_i     redirect select and target
//   insn_vld_i               decoded instruction is legal
//   instr_o, pc_o, pc_four_o instruction, its pc, and pc + 4
//   instr_valid_o            one execute window per instruction
//   trap_o, trap_pc_o        halted, and pc of the offending instruction
//   instret_o                retired-instruction counter
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        pc_sel_i,
  input  logic        insn_vld_i,
  input  logic [31:0] alu_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_four_o,
  output logic        instr_valid_o,
  output logic        trap_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] instret_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    TRAP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] pc_four;
  logic [31:0] tgt;
  logic        bad_tgt;

  assign pc_four = pc_q + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
  assign tgt     = alu_data_i;
  assign bad_tgt = pc_sel_i && (alu_data_i[1:0] != 2'b00);
`else
  // Low bits are dropped so a misaligned target still fetches a word.
  assign tgt     = alu_data_i & ~32'h3;
  assign bad_tgt = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    trap_pc_d = trap_pc_q;
    instret_d = instret_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Illegal instruction wins over stall.
        if (!insn_vld_i || (!stall_i && bad_tgt)) begin
          trap_pc_d = pc_q;
          instr_d   = NOP_INSN;
          state_d   = TRAP;
        end else if (!stall_i) begin
          pc_d      = pc_sel_i ? tgt : pc_four;
          instret_d = instret_q + 32'd1;
          instr_d   = NOP_INSN;
          state_d   = REQ;
        end
      end
      TRAP: state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSN;
      trap_pc_q <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      trap_pc_q <= trap_pc_d;
      instret_q <= instret_d;
    end
  end

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_four_o     = pc_four;
  assign instr_valid_o = (state_q == EXEC);
  assign trap_o        = (state_q == TRAP);
  assign trap_pc_o     = trap_pc_q;
  assign instret_o     = instret_q;

endmodule
